// File: rtl/instr_encoder_pkg.sv
// Shared constants for the instruction encoder: format codes, opcodes and the
// decoded field bundle handed to the packer.
package instr_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } fields_t;

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters the immediate into the RV32I word for the
// selected format and flags immediates the format cannot represent.
module imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  fields_t     fields,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    localparam logic signed [31:0] IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IS_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN  = -32'sd4096;
    localparam logic signed [31:0] B_MAX  = 32'sd4094;
    localparam logic signed [31:0] J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] J_MAX  = 32'sd1048574;

    logic signed [31:0] simm;

    function automatic logic fits(input logic signed [31:0] v,
                                  input logic signed [31:0] lo,
                                  input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign simm = imm;

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                        fields.rd, fields.opcode};
            end
            FMT_I: begin
                word    = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
                illegal = !fits(simm, IS_MIN, IS_MAX);
            end
            FMT_S: begin
                word    = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                           imm[4:0], fields.opcode};
                illegal = !fits(simm, IS_MIN, IS_MAX);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                           imm[4:1], imm[11], fields.opcode};
                illegal = !fits(simm, B_MIN, B_MAX) || imm[0];
            end
            FMT_U: begin
                word    = {imm[31:12], fields.rd, fields.opcode};
                illegal = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
                illegal = !fits(simm, J_MIN, J_MAX) || imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Session-based instruction loader: accepts decoded field sets, encodes them and
// writes the words sequentially into instruction memory from a latched base.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [2:0]             fmt,
    input  logic [6:0]             opcode,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [31:0]            imm,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    output logic                   done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    fields_t           fields;
    logic [31:0]       word;
    logic              illegal;
    logic              accept;
    logic              reject;

    assign fields   = {funct7, rs2, rs1, funct3, rd, opcode};
    assign in_ready = (state == ST_RUN);
    assign done     = (state == ST_DONE);
    assign accept   = in_valid && in_ready;
    // A full memory is treated like a bad immediate: consume the item, never write.
    assign reject   = illegal || (count == CNT_FULL);

    imm_pack u_imm_pack (
        .fmt     (fmt),
        .fields  (fields),
        .imm     (imm),
        .word    (word),
        .illegal (illegal)
    );

    // Acceptance -> registered write port, one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            count      <= '0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        base_q <= base_addr;
                        count  <= '0;
                        err    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= base_q + (ADDR_W'(count) << 2);
                            imem_wdata <= word;
                            count      <= count + 1'b1;
                        end
                        if (in_last) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default-depth instance and a DEPTH=2
// instance share the field bus; each has its own expected-write queue.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cnt;
        logic        last;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [2:0]  fmt = '0, funct3 = '0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;

    logic        a_ready, a_we, a_err, a_done;
    logic [31:0] a_addr, a_wdata;
    logic [8:0]  a_count;
    logic        b_ready, b_we, b_err, b_done;
    logic [31:0] b_addr, b_wdata;
    logic [1:0]  b_count;

    wr_t         qa[$], qb[$];
    int          cnt_a = 0, cnt_b = 0;
    logic [31:0] base_a = '0, base_b = '0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(256), .ADDR_W(32)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(a_ready), .in_last(in_last),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .count(a_count), .err(a_err), .done(a_done)
    );

    instr_encoder #(.DEPTH(2), .ADDR_W(32)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(b_ready), .in_last(in_last),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .count(b_count), .err(b_err), .done(b_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (a_we) begin
            if (qa.size() == 0) chk("a_unexpected_we", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_addr", a_addr, e.addr);
                chk("a_wdata", a_wdata, e.data);
                chk("a_count", a_count, e.cnt);
                chk("a_done", a_done, e.last);
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (b_we) begin
            if (qb.size() == 0) chk("b_unexpected_we", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_addr", b_addr, e.addr);
                chk("b_wdata", b_wdata, e.data);
                chk("b_count", b_count, e.cnt);
                chk("b_done", b_done, e.last);
            end
        end
    end

    task automatic start_sess(input bit sel, input logic [31:0] base);
        @(negedge clk);
        base_addr = base;
        if (sel) begin start_b = 1'b1; base_b = base; cnt_b = 0; end
        else     begin start_a = 1'b1; base_a = base; cnt_a = 0; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send(input bit sel, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                        input bit last, input bit wr, input logic [31:0] word);
        int  n;
        wr_t e;
        n = 0;
        while (!(sel ? b_ready : a_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", n, 0);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im; in_last = last; in_valid = 1'b1;
        if (wr) begin
            e.data = word;
            e.last = last;
            if (sel) begin
                e.addr = base_b + 32'(4 * cnt_b); cnt_b++; e.cnt = cnt_b; qb.push_back(e);
            end else begin
                e.addr = base_a + 32'(4 * cnt_a); cnt_a++; e.cnt = cnt_a; qa.push_back(e);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_we", a_we, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_count", a_count, 0);
        chk("rst_err", a_err, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ready", a_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        start_sess(0, 32'h100);
        send(0, FMT_I, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 1, 32'h00500093);

        start_sess(0, 32'h100);
        send(0, FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 0, 1, 32'h0020A423);
        send(0, FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1, 1, 32'hFE208EE3);

        start_sess(0, 32'h200);
        send(0, FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0, 1, 32'h123452B7);
        send(0, FMT_R, OP_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 0, 1, 32'h402081B3);
        send(0, FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1, 1, 32'h001000EF);

        // Illegal items: all consumed silently, the last one still ends the session.
        start_sess(0, 32'h300);
        send(0, FMT_I, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 0, 32'd0);
        send(0, FMT_B, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0, 0, 32'd0);
        send(0, 3'd6, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1, 0, 32'd0);
        chk("ill_done", a_done, 1);
        chk("ill_err", a_err, 1);
        chk("ill_count", a_count, 0);
        @(negedge clk);
        chk("ill_err_sticky", a_err, 1);
        chk("ill_done_clr", a_done, 0);
        start_sess(0, 32'h300);
        chk("err_cleared", a_err, 0);
        send(0, FMT_I, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 1, 32'h00500093);

        // Overflow on the DEPTH=2 instance.
        start_sess(1, 32'h40);
        send(1, FMT_I, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 0, 1, 32'h00100093);
        send(1, FMT_I, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 0, 1, 32'h00200093);
        send(1, FMT_I, OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1, 0, 32'd0);
        chk("ovf_done", b_done, 1);
        chk("ovf_err", b_err, 1);
        chk("ovf_count", b_count, 2);

        // Reset right after an acceptance drops the pending write.
        start_sess(0, 32'h400);
        fmt = FMT_I; opcode = OP_OPIMM; rd = 5'd1; rs1 = 5'd0; funct3 = 3'd0;
        imm = 32'd7; in_last = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", a_we, 0);
        chk("mid_rst_addr", a_addr, 0);
        chk("mid_rst_wdata", a_wdata, 0);
        chk("mid_rst_count", a_count, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_done", a_done, 0);
        chk("mid_rst_ready", a_ready, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", a_ready, 0);

        repeat (3) @(negedge clk);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder for the single-cycle CPU test infrastructure. It is the inverse of the immediate generator: it accepts decoded instruction fields plus a full 32-bit immediate, range-checks the immediate, and packs it into a RISC-V RV32I instruction word. Encoded words are written sequentially into instruction memory through a write port, so benches and boot logic can load programs without a pre-built hex file.

## Interface
- `DEPTH`, 256: instruction memory capacity in words.
- `ADDR_W`, 32: width of the byte address on the write port.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse: begin a load session at `base_addr`.
- `base_addr`  in  ADDR_W  byte address of the first word; must be word-aligned.
- `in_valid`  in  1  field set present.
- `in_ready`  out  1  encoder accepts a field set this cycle.
- `in_last`  in  1  marks the final instruction of the session.
- `fmt`  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `opcode`  in  7  opcode.
- `rd`, `rs1`, `rs2`  in  5 each  register fields.
- `funct3`  in  3  function code.
- `funct7`  in  7  function code (R only).
- `imm`  in  32  signed immediate (byte offset for B and J).
- `imem_we`  out  1  one-cycle write strobe.
- `imem_addr`  out  ADDR_W  byte write address.
- `imem_wdata`  out  32  encoded instruction.
- `count`  out  $clog2(DEPTH)+1  words written this session.
- `err`  out  1  sticky error flag; cleared by `start` or `rst`.
- `done`  out  1  one-cycle pulse when the session ends.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`. This latches `base_addr` and clears `count` and `err`.
- RUN → DONE on acceptance with `in_last` = 1.
- DONE → IDLE unconditionally. `done` = 1 while in DONE.
- `start` is ignored outside IDLE.
- `in_ready` = 1 only in RUN. Acceptance occurs when `in_valid && in_ready`.
- Packing, by format:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
- Immediate legality rules:
  - I/S: −2048..2047.
  - B: −4096..4094 and even.
  - J: −2^20..2^20−2 and even.
  - U: imm[11:0] = 0.
  - R: `imm` is ignored.
- Any of the following is an error: an illegal `fmt`, an illegal immediate, or acceptance while `count` = DEPTH (overflow).
  - An erroring item is consumed, with no write and no `count` increment.
  - `err` is set and stays set.
  - An erroring `in_last` still ends the session.
- Write address = latched base + 4·`count`, computed at acceptance.
- `count` saturates at DEPTH.

## Timing
- Latency: `imem_we`, `imem_addr` and `imem_wdata` are registered and valid exactly 1 cycle after acceptance. One write can occur per cycle; back-to-back acceptance gives back-to-back writes.
- Sequencing of the last write and `done`:
  - The `count` increment is visible in the same cycle as the corresponding `imem_we`.
  - `done` asserts in the same cycle as the last write (the cycle after the `in_last` acceptance).
- Reset values: state IDLE, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `count` 0, `err` 0, `done` 0, `in_ready` 0.
- Reset mid-session: the session is abandoned immediately and any pending write strobe is dropped.
- `start` with `in_valid` in the same IDLE cycle: only the start is taken; the first acceptance is possible in the next cycle.

## Structure
- Shared package/header `parameters.vh` holds:
  - the format codes (`FMT_R` … `FMT_J`);
  - the existing opcode constants, reused for tests.
- One combinational sub-module, `imm_pack`: (fmt, fields, imm) → (word, illegal). The FSM, counter, address and output registers live in `instr_encoder`.

## Test plan
- I-type addi (op 0x13, rd 1, rs1 0, f3 0, imm 5) at base 0x100 → one write 0x00500093 at 0x100; `count` 1.
- S-type sw (op 0x23, f3 2, rs1 1, rs2 2, imm 8), then B-type beq (op 0x63, rs1 1, rs2 2, imm −4, `in_last`), back-to-back:
  - writes 0x0020A423 @0x100 then 0xFE208EE3 @0x104;
  - `done` pulses together with the second write.
- U-type lui (op 0x37, rd 5, imm 0x12345000) → 0x123452B7. J-type jal (op 0x6F, rd 1, imm 2048) → 0x001000EF.
- Illegal inputs: I imm 2048, B imm 3, and `fmt` 6 → no writes, `count` unchanged, `err` = 1 until the next `start`.
- DEPTH=2, three items → two writes, the third is dropped, `err` = 1, `count` = 2.
- Assert `rst` one cycle after an acceptance → no `imem_we` pulse; all outputs return to reset values; state IDLE.
